dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum BUSY cycles without mem_ack before the access is aborted.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 MemRead  in  1  core requests load this cycle.
REQ-005 MemWrite  in  1  core requests store this cycle.
REQ-006 ALUResult  in  32  byte address from core ALU.
REQ-007 WriteData  in  32  store data from core register file.
REQ-008 ReadData  out  32  load data returned to core result mux.
REQ-009 Stall  out  1  core shall hold PC and register writes while high.
REQ-010 BusErr  out  1  sticky error flag (misaligned or timeout).
REQ-011 mem_req  out  1  memory request, registered.
REQ-012 mem_we  out  1  1=write, 0=read, registered, valid with mem_req.
REQ-013 mem_addr  out  32  word-aligned address, registered, valid with mem_req.
REQ-014 mem_wdata  out  32  store data, registered, valid with mem_req.
REQ-015 mem_ack  in  1  memory completion; sampled only while mem_req=1.
REQ-016 mem_rdata  in  32  read data, valid in the cycle mem_ack=1.

Function
REQ-017 States IDLE, BUSY, DONE; encoding is free.
REQ-018 Req = MemRead | MemWrite; Aligned = (ALUResult[1:0] == 2'b00).
REQ-019 IDLE, Req & Aligned: latch mem_addr=ALUResult, mem_wdata=WriteData, mem_we=MemWrite; next state BUSY.
REQ-020 IDLE, Req & !Aligned: no bus cycle; set BusErr; remain IDLE; Stall=0; ReadData unchanged.
REQ-021 MemRead and MemWrite both high: treated as a write (mem_we=1).
REQ-022 Stall combinational = (IDLE & Req & Aligned) | BUSY; Stall=0 in DONE.
REQ-023 mem_req=1 exactly while in BUSY; mem_addr/mem_we/mem_wdata stable throughout BUSY.
REQ-024 BUSY, mem_ack=1: if read, ReadData <= mem_rdata; if write, ReadData unchanged; next state DONE; timeout counter cleared.
REQ-025 BUSY, mem_ack=0: timeout counter +1; when counter reaches TIMEOUT, set BusErr; if read, ReadData <= 32'h0; next state DONE.
REQ-026 Minimum latency: request cycle N (IDLE), mem_req high in cycle N+1, ack in N+1 gives DONE in N+2 with Stall=0; two stall cycles per access.
REQ-027 DONE: unconditional return to IDLE next cycle; Req in DONE is ignored (it belongs to the completed instruction).
REQ-028 ReadData holds its value until the next completed read.
REQ-029 BusErr is sticky; cleared only by reset.
REQ-030 mem_ack outside BUSY is ignored.
REQ-031 Timeout counter 8 bits wide, saturating never reached past TIMEOUT.

Reset
REQ-032 On reset assertion, asynchronously: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData=0, BusErr=0, counter=0.
REQ-033 Reset during BUSY aborts the access; mem_req drops without waiting for mem_ack.
REQ-034 First request is accepted on the first rising edge after reset deasserts.

Verification
REQ-035 Load ALUResult=0x100, ack one cycle after mem_req, mem_rdata=0xCAFEF00D -> Stall high 2 cycles, ReadData=0xCAFEF00D in DONE, BusErr=0.
REQ-036 Store ALUResult=0x20, WriteData=0x12345678, ack after 3 cycles -> mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 stable 3 cycles, Stall high 4 cycles.
REQ-037 Load ALUResult=0x102 -> mem_req stays 0, Stall=0, BusErr=1 next cycle.
REQ-038 Load with mem_ack never asserted -> BUSY for TIMEOUT cycles (255), then DONE, ReadData=0, BusErr=1.
REQ-039 MemRead=MemWrite=1 at 0x40 -> mem_we=1 store cycle.
REQ-040 Reset asserted mid-BUSY -> mem_req=0 and Stall=0 in the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns single-cycle core load/store requests into a
// registered req/ack bus cycle, stalling the core until the access finishes.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req;
    logic        aligned;
    logic [8:0]  cnt_inc;

    assign req     = MemRead | MemWrite;
    assign aligned = (ALUResult[1:0] == 2'b00);
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        Stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && aligned) begin
                    Stall   = 1'b1;
                    addr_d  = ALUResult;
                    wdata_d = WriteData;
                    we_d    = MemWrite;
                    req_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                end else if (req) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (mem_ack) begin
                    if (!we_q) rdata_d = mem_rdata;
                    cnt_d   = 8'd0;
                    state_d = DONE;
                end else if (cnt_inc == 9'(TIMEOUT)) begin
                    // Abandon the access; a timed-out load returns zero.
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = 32'h0;
                    cnt_d   = 8'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc[7:0];
                    req_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ReadData  = rdata_q;
    assign BusErr    = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: inputs change just after the rising edge,
// outputs are sampled on the falling edge.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Stall, BusErr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .BusErr    (BusErr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic idle_inputs();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ALUResult = 32'h0;
        WriteData = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({mem_req, mem_we, Stall, BusErr} !== 4'b0000) begin
            $display("FAIL reset_ctrl: got %b want 0000",
                     {mem_req, mem_we, Stall, BusErr});
        end else passed++;
        total++;
        if ({mem_addr, mem_wdata, ReadData} !== 96'h0) begin
            $display("FAIL reset_data: addr %h wdata %h rdata %h want 0",
                     mem_addr, mem_wdata, ReadData);
        end else passed++;
    endtask

    // Load at 0x100, ack in the first BUSY cycle.
    task automatic test_load();
        int stalls = 0;
        @(posedge clk); #1;
        MemRead   = 1'b1;
        ALUResult = 32'h100;
        @(negedge clk);
        if (Stall) stalls++;
        total++;
        if (mem_req !== 1'b0) begin
            $display("FAIL load_req_early: got %b want 0", mem_req);
        end else passed++;
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        if (Stall) stalls++;
        total++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            $display("FAIL load_bus: req %b we %b addr %h want 1 0 00000100",
                     mem_req, mem_we, mem_addr);
        end else passed++;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        MemRead = 1'b0;
        @(negedge clk);
        if (Stall) stalls++;
        total++;
        if (ReadData !== 32'hCAFEF00D || BusErr !== 1'b0 || mem_req !== 1'b0) begin
            $display("FAIL load_done: rdata %h err %b req %b want cafef00d 0 0",
                     ReadData, BusErr, mem_req);
        end else passed++;
        total++;
        if (stalls != 2) begin
            $display("FAIL load_stalls: got %0d want 2", stalls);
        end else passed++;
    endtask

    // Store at 0x20, ack arrives in the third BUSY cycle.
    task automatic test_store();
        int stalls = 0;
        int bad    = 0;
        @(posedge clk); #1;
        MemWrite  = 1'b1;
        ALUResult = 32'h20;
        WriteData = 32'h12345678;
        @(negedge clk);
        if (Stall) stalls++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_ack = (i == 2);
            @(negedge clk);
            if (Stall) stalls++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !==
                {1'b1, 1'b1, 32'h20, 32'h12345678}) bad++;
        end
        total++;
        if (bad != 0) begin
            $display("FAIL store_bus_stable: %0d bad cycles want 0", bad);
        end else passed++;
        @(posedge clk); #1;
        mem_ack  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        if (Stall) stalls++;
        total++;
        if (stalls != 4) begin
            $display("FAIL store_stalls: got %0d want 4", stalls);
        end else passed++;
        total++;
        if (ReadData !== 32'hCAFEF00D || mem_req !== 1'b0) begin
            $display("FAIL store_done: rdata %h req %b want cafef00d 0",
                     ReadData, mem_req);
        end else passed++;
    endtask

    // Read and write together behave as a store.
    task automatic test_both();
        @(posedge clk); #1;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        ALUResult = 32'h40;
        WriteData = 32'hA5A5A5A5;
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !==
            {1'b1, 1'b1, 32'h40, 32'hA5A5A5A5}) begin
            $display("FAIL both_we: req %b we %b addr %h wdata %h want 1 1 40 a5a5a5a5",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end else passed++;
        @(posedge clk); #1;
        mem_ack  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        total++;
        if (ReadData !== 32'hCAFEF00D) begin
            $display("FAIL both_rdata: got %h want cafef00d", ReadData);
        end else passed++;
    endtask

    task automatic test_ack_outside();
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (ReadData !== 32'hCAFEF00D || mem_req !== 1'b0 || Stall !== 1'b0) begin
            $display("FAIL ack_idle: rdata %h req %b stall %b want cafef00d 0 0",
                     ReadData, mem_req, Stall);
        end else passed++;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    task automatic test_misaligned();
        @(posedge clk); #1;
        MemRead   = 1'b1;
        ALUResult = 32'h102;
        @(negedge clk);
        total++;
        if (Stall !== 1'b0 || BusErr !== 1'b0) begin
            $display("FAIL misal_now: stall %b err %b want 0 0", Stall, BusErr);
        end else passed++;
        @(posedge clk); #1;
        MemRead = 1'b0;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || BusErr !== 1'b1 || ReadData !== 32'hCAFEF00D) begin
            $display("FAIL misal_next: req %b err %b rdata %h want 0 1 cafef00d",
                     mem_req, BusErr, ReadData);
        end else passed++;
    endtask

    // Fresh reset, a good load to make ReadData nonzero, then a load nobody acks.
    task automatic test_timeout();
        int busy = 0;
        apply_reset();
        @(posedge clk); #1;
        MemRead   = 1'b1;
        ALUResult = 32'h80;
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h11112222;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        MemRead   = 1'b0;
        @(posedge clk); #1;
        MemRead   = 1'b1;
        ALUResult = 32'h200;
        @(posedge clk);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mem_req) busy++;
            else break;
        end
        MemRead = 1'b0;
        total++;
        if (busy != 255) begin
            $display("FAIL timeout_len: got %0d busy cycles want 255", busy);
        end else passed++;
        total++;
        if (Stall !== 1'b0 || ReadData !== 32'h0 || BusErr !== 1'b1) begin
            $display("FAIL timeout_done: stall %b rdata %h err %b want 0 0 1",
                     Stall, ReadData, BusErr);
        end else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (BusErr !== 1'b1) begin
            $display("FAIL timeout_sticky: err %b want 1", BusErr);
        end else passed++;
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1;
        MemWrite  = 1'b1;
        ALUResult = 32'h300;
        WriteData = 32'h55AA55AA;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1) begin
            $display("FAIL rst_busy_pre: req %b want 1", mem_req);
        end else passed++;
        #1;
        reset    = 1'b1;
        MemWrite = 1'b0;
        #1;
        total++;
        if ({mem_req, mem_we, Stall, BusErr} !== 4'b0000 ||
            {mem_addr, mem_wdata, ReadData} !== 96'h0) begin
            $display("FAIL rst_busy: req %b we %b stall %b err %b addr %h want all 0",
                     mem_req, mem_we, Stall, BusErr, mem_addr);
        end else passed++;
        @(negedge clk);
        reset     = 1'b0;
        MemRead   = 1'b1;
        ALUResult = 32'h44;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin
            $display("FAIL rst_first_req: req %b addr %h want 1 00000044",
                     mem_req, mem_addr);
        end else passed++;
        MemRead   = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h77778888;
        @(negedge clk);
        mem_ack = 1'b0;
        total++;
        if (ReadData !== 32'h77778888 || Stall !== 1'b0) begin
            $display("FAIL rst_first_done: rdata %h stall %b want 77778888 0",
                     ReadData, Stall);
        end else passed++;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load();
        test_store();
        test_both();
        test_ack_outside();
        test_misaligned();
        test_timeout();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
